// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches from instruction memory with a timeout.
// Optional macro MISALIGN_CHECK_EN adds a sticky align_err output that blocks misaligned PC loads.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instrReg,
    input  logic        pc_we,
    input  logic        jump,
    input  logic        jr,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        ir_ready,
    output logic        busy,
    output logic        fetch_err,
`ifdef MISALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] ir;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        branch_taken;

    assign state_dbg = state;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign imm16  = ir[15:0];
    assign funct  = ir[5:0];

    assign pc_plus4 = pc + 32'd4;

    // Memory handshake: imem_req rises with imem_addr latched and both stay
    // stable until the cycle imem_valid is sampled high (data taken from
    // imem_rdata on that edge) or until TIMEOUT wait cycles pass without it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir        <= 32'h0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ir_ready  <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            ir_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (instrReg) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                        wait_cnt  <= 8'd0;
                        fetch_err <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        ir       <= imem_rdata;
                        ir_ready <= 1'b1;
                        imem_req <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // jr beats jump beats branch; a fall-through is plain sequential flow.
    always_comb begin
        branch_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
        branch_taken = (beq & zero) | (bne & ~zero);
        next_pc      = pc_plus4;
        if (jr) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            align_err <= 1'b0;
        end else if (pc_we) begin
            if (next_pc[1:0] != 2'b00) begin
                align_err <= 1'b1;
            end else begin
                pc <= next_pc;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (pc_we) begin
            pc <= next_pc;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: fetch scoreboard plus next-PC, timeout and reset checks.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        instrReg;
    logic        pc_we;
    logic        jump;
    logic        jr;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [31:0] rs_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ir_ready;
    logic        busy;
    logic        fetch_err;
    logic        state_dbg;
`ifdef MISALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ir_obs;

    assign ir_obs = {opcode, rs, rt, imm16};

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instrReg   (instrReg),
        .pc_we      (pc_we),
        .jump       (jump),
        .jr         (jr),
        .beq        (beq),
        .bne        (bne),
        .zero       (zero),
        .rs_data    (rs_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .opcode     (opcode),
        .funct      (funct),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm16      (imm16),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .ir_ready   (ir_ready),
        .busy       (busy),
        .fetch_err  (fetch_err),
`ifdef MISALIGN_CHECK_EN
        .align_err  (align_err),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ir_ready must match the oldest word handed to memory.
    always @(negedge clk) begin
        if (rst_n && ir_ready) begin
            if (exp_q.size() == 0) check("ir_unexpected", 32'd1, 32'd0);
            else check("ir_word", ir_obs, exp_q.pop_front());
        end
    end

    // Drivers
    task automatic do_fetch(input logic [31:0] word, input int delay, input logic [31:0] addr);
        @(negedge clk) instrReg = 1'b1;
        @(negedge clk) instrReg = 1'b0;
        check("req_up", imem_req, 1);
        check("busy_up", busy, 1);
        check("fetch_addr", imem_addr, addr);
        repeat (delay) @(negedge clk);
        check("no_early_ready", ir_ready, 0);
        imem_valid = 1'b1;
        imem_rdata = word;
        exp_q.push_back(word);
        @(negedge clk) imem_valid = 1'b0;
        check("ir_ready_pulse", ir_ready, 1);
        check("busy_down", busy, 0);
        check("req_down", imem_req, 0);
        @(negedge clk);
        check("ir_ready_once", ir_ready, 0);
    endtask

    task automatic pc_step(input logic j_r, input logic j, input logic b_eq, input logic b_ne,
                           input logic z, input logic [31:0] rsv);
        @(negedge clk);
        jr = j_r; jump = j; beq = b_eq; bne = b_ne; zero = z; rs_data = rsv; pc_we = 1'b1;
        @(negedge clk);
        jr = 0; jump = 0; beq = 0; bne = 0; zero = 0; pc_we = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; instrReg = 0; pc_we = 0; jump = 0; jr = 0; beq = 0; bne = 0;
        zero = 0; rs_data = 0; imem_rdata = 0; imem_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_opcode", {26'd0, opcode}, 32'h0);
        check("rst_funct", {26'd0, funct}, 32'h0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_busy", busy, 0);
        check("rst_err", fetch_err, 0);
        check("rst_ready", ir_ready, 0);
        check("rst_state", state_dbg, 0);
`ifdef MISALIGN_CHECK_EN
        check("rst_align", align_err, 0);
`endif
        rst_n = 1'b1;

        // 1: SLT fetch with one wait cycle
        do_fetch(32'h0000_002A, 1, 32'h0);
        check("slt_opcode", {26'd0, opcode}, 32'h0);
        check("slt_funct", {26'd0, funct}, 32'h2A);

        // 2: branches (minimum-latency fetch of BEQ imm=3)
        do_fetch(32'h1000_0003, 0, 32'h0);
        pc_step(1, 0, 0, 0, 0, 32'h10);
        check("jr_set", pc, 32'h10);
        pc_step(0, 0, 1, 0, 1, 32'h0);
        check("beq_taken", pc, 32'h20);
        pc_step(1, 0, 0, 0, 0, 32'h10);
        pc_step(0, 0, 0, 1, 1, 32'h0);
        check("bne_not_taken", pc, 32'h14);
        do_fetch(32'h1400_FFFE, 2, 32'h14);
        pc_step(1, 0, 0, 0, 0, 32'h100);
        pc_step(0, 0, 0, 1, 0, 32'h0);
        check("bne_backward", pc, 32'hFC);
        pc_step(0, 0, 1, 0, 0, 32'h0);
        check("beq_not_taken", pc, 32'h100);

        // pc update during an outstanding fetch leaves the latched address alone
        pc_step(1, 0, 0, 0, 0, 32'h14);
        @(negedge clk) instrReg = 1'b1;
        @(negedge clk) instrReg = 1'b0; pc_we = 1'b1;
        @(negedge clk) pc_we = 1'b0;
        check("pc_during_fetch", pc, 32'h18);
        check("addr_held", imem_addr, 32'h14);
        imem_valid = 1'b1; imem_rdata = 32'h0C00_0040; exp_q.push_back(32'h0C00_0040);
        @(negedge clk) imem_valid = 1'b0;
        check("jal_ready", ir_ready, 1);

        // 3: JAL target and jr priority
        pc_step(1, 0, 0, 0, 0, 32'h8000_0000);
        check("jal_link", pc_plus4, 32'h8000_0004);
        pc_step(0, 1, 0, 0, 0, 32'h0);
        check("jal_target", pc, 32'h8000_0100);
        pc_step(1, 1, 0, 0, 0, 32'h44);
        check("jr_over_jump", pc, 32'h44);

        // 4: timeout
        @(negedge clk) instrReg = 1'b1;
        @(negedge clk) instrReg = 1'b0;
        cnt = 0;
        while (imem_req && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_cycles", cnt, 15);
        check("timeout_err", fetch_err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_ir", ir_obs, 32'h0C00_0040);
        @(negedge clk) instrReg = 1'b1;
        @(negedge clk) instrReg = 1'b0;
        check("err_cleared", fetch_err, 0);
        imem_valid = 1'b1; imem_rdata = 32'h2108_0001; exp_q.push_back(32'h2108_0001);
        @(negedge clk) imem_valid = 1'b0;
        check("refetch_ready", ir_ready, 1);

        // 5: reset in WAIT aborts, late valid ignored
        @(negedge clk) instrReg = 1'b1;
        @(negedge clk) instrReg = 1'b0;
        check("abort_req", imem_req, 1);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("abort_pc", pc, 32'h0);
        check("abort_req_low", imem_req, 0);
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk) imem_valid = 1'b0;
        check("abort_no_ready", ir_ready, 0);
        check("abort_ir", ir_obs, 32'h0);
        check("abort_state", state_dbg, 0);

        // 6: wraparound and misalignment
        pc_step(1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        pc_step(0, 0, 0, 0, 0, 32'h0);
        check("wrap_pc", pc, 32'h0);
`ifdef MISALIGN_CHECK_EN
        pc_step(1, 0, 0, 0, 0, 32'h6);
        check("misalign_pc", pc, 32'h0);
        check("misalign_err", align_err, 1);
`else
        pc_step(1, 0, 0, 0, 0, 32'h6);
        check("unaligned_load", pc, 32'h6);
`endif

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
